conv_stream_filter: RTL and testbench
=====================================

CONV_STREAM_FILTER -- requirements
Module: conv_stream_filter

Interface
REQ-001 Parameter PIXEL_W, default 4: grayscale pixel width in bits (4..8).
REQ-002 Parameter LINE_W, default 640: pixels per line (4..2048).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 enable  input  1  0 = windowed passthrough of centre pixel.
REQ-006 kernel_select  input  3  0 Gaussian, 1 Sobel, 2 Sharpen, 3 Emboss, 4 Custom, 5-7 passthrough.
REQ-007 coef  input  9x4  signed custom coefficients c00..c22, row-major.
REQ-008 coef_shift  input  3  arithmetic right shift applied to the custom sum.
REQ-009 in_valid / in_ready  input / output  1 / 1  input pixel handshake.
REQ-010 in_pixel  input  PIXEL_W  unsigned input pixel, raster order.
REQ-011 in_sof / in_sol  input  1 / 1  start of frame / start of line, qualified by in_valid.
REQ-012 out_valid / out_ready  output / input  1 / 1  output pixel handshake.
REQ-013 out_pixel  output  PIXEL_W  filtered pixel.
REQ-014 out_sof / out_sol  output  1 / 1  first output pixel of frame / of line.

Function
REQ-015 Transfer occurs when valid && ready; in_ready = !out_valid || out_ready (combinational).
REQ-016 Two-stage pipeline (window/MAC, clamp/output register); it advances only on in_ready; out_valid asserts 2 cycles after the accepting edge.
REQ-017 Column counter increments per accepted pixel and wraps LINE_W-1 -> 0; row counter increments on wrap and saturates at 2.
REQ-018 Accepted pixel with in_sof forces row=0, col=0; with in_sol forces col=0; in_sof takes priority.
REQ-019 Output produced only for accepted pixel at row>=2, col>=2; window centre = (row-1, col-1); output frame is (H-2)x(LINE_W-2).
REQ-020 out_sof marks the first output after in_sof; out_sol marks outputs where col==2.
REQ-021 enable, kernel_select, coef, coef_shift are latched on the accepted in_sof pixel; mid-frame changes are ignored.
REQ-022 Gaussian: [1 2 1;2 4 2;1 2 1], (sum+8)>>4.
REQ-023 Sobel: (|Gx|+|Gy|)>>2, Gx=[-1 0 1;-2 0 2;-1 0 1], Gy=[-1 -2 -1;0 0 0;1 2 1].
REQ-024 Sharpen: [0 -1 0;-1 5 -1;0 -1 0]. Emboss: [-2 -1 0;-1 1 1;0 1 2] plus 2^(PIXEL_W-1).
REQ-025 Custom: sum of cij*pij, arithmetic shift right by coef_shift.
REQ-026 Accumulator signed PIXEL_W+7 bits; final result clamped to [0, 2^PIXEL_W-1], never wrapped.
REQ-027 Stall (out_valid && !out_ready): out_pixel, out_valid, flags, and all window/line state hold.

Reset
REQ-028 On rst_n low: out_valid=0, out_pixel=0, out_sof=0, out_sol=0, counters=0, window registers=0, latched mode=Gaussian, enable latch=1.
REQ-029 Line-buffer RAM is not reset; reset mid-frame discards the partial frame; no output until two complete new rows are received.

Structure
REQ-030 Package conv_pkg holds kernel mode enum, fixed kernel coefficient constants, coefficient array typedef.
REQ-031 Sub-module conv_line_buffer: LINE_W-deep RAM, 2*PIXEL_W wide, storing the previous two lines, one read/write per accepted pixel.

Verification (PIXEL_W=4, LINE_W=8, 8x8 frames)
REQ-032 Constant 9, Gaussian -> 36 outputs all 9; first out_valid 2 cycles after pixel (2,2) accepted, with out_sof=1.
REQ-033 Cols 0-3=0, cols 4-7=15, Sobel -> centre cols 3,4 output 15; all other outputs 0.
REQ-034 Single 15 at (4,4) on 0 background, Sharpen -> centre 15 (75 clamped); its 4-neighbours 0 (-15 clamped).
REQ-035 Flat 5, Emboss -> 13 everywhere; kernel_select changed to 1 mid-frame -> still 13 until next in_sof.
REQ-036 out_ready low 5 cycles mid-line -> in_ready low, out_pixel held; total 36 outputs, none lost or duplicated.
REQ-037 rst_n pulsed after row 4 -> out_valid 0 immediately; next frame first output only after its row 2, col 2.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Brief  : Kernel modes, fixed 3x3 kernels and coefficient types for the
//          streaming convolution filter.
// Rev    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        K_GAUSS   = 3'd0,
        K_SOBEL   = 3'd1,
        K_SHARPEN = 3'd2,
        K_EMBOSS  = 3'd3,
        K_CUSTOM  = 3'd4,
        K_PASS_5  = 3'd5,
        K_PASS_6  = 3'd6,
        K_PASS_7  = 3'd7
    } kernel_e;

    localparam int c_COEF_W = 4;
    localparam int c_TAPS   = 9;

    // Tap index is row-major: 3*row + col, so index 4 is the window centre.
    typedef logic signed [c_COEF_W-1:0] coef_t;
    typedef coef_t [c_TAPS-1:0]         coef_arr_t;
    typedef int                         kernel_arr_t [c_TAPS];

    localparam kernel_arr_t c_K_GAUSS   = '{ 1,  2,  1,  2, 4, 2,  1,  2,  1};
    localparam kernel_arr_t c_K_SOBEL_X = '{-1,  0,  1, -2, 0, 2, -1,  0,  1};
    localparam kernel_arr_t c_K_SOBEL_Y = '{-1, -2, -1,  0, 0, 0,  1,  2,  1};
    localparam kernel_arr_t c_K_SHARPEN = '{ 0, -1,  0, -1, 5, -1, 0, -1,  0};
    localparam kernel_arr_t c_K_EMBOSS  = '{-2, -1,  0, -1, 1, 1,  0,  1,  2};

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module : conv_line_buffer
// Brief  : Column-addressed RAM holding the two previous lines {top, mid}.
// Rev    : 1.0 - initial release
// ============================================================================
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int PIXEL_W = 4,
    parameter int LINE_W  = 640
) (
    input  logic                                      clk,
    input  logic                                      wr_en,
    input  logic [((LINE_W > 1) ? $clog2(LINE_W) : 1)-1:0] addr,
    input  logic [PIXEL_W-1:0]                        wr_top,
    input  logic [PIXEL_W-1:0]                        wr_mid,
    output logic [PIXEL_W-1:0]                        rd_top,
    output logic [PIXEL_W-1:0]                        rd_mid
);

    logic [2*PIXEL_W-1:0] r_mem [LINE_W];

    // Read-before-write at the same column: the read returns the lines
    // above the pixel being written.
    assign {rd_top, rd_mid} = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= {wr_top, wr_mid};
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_stream_filter.sv
`default_nettype none
// ============================================================================
// Module : conv_stream_filter
// Brief  : 3x3 streaming convolution filter with valid/ready handshakes.
// Rev    : 1.0 - initial release
// ============================================================================
module conv_stream_filter
    import conv_pkg::*;
#(
    parameter int PIXEL_W = 4,
    parameter int LINE_W  = 640
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [2:0]         kernel_select,
    input  coef_arr_t          coef,
    input  logic [2:0]         coef_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_sof,
    input  logic               in_sol,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_sof,
    output logic               out_sol
);

    localparam int c_COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int c_ACC_W = PIXEL_W + 7;
    localparam int c_EMBOSS_OFS = 1 << (PIXEL_W - 1);
    localparam logic signed [c_ACC_W-1:0] c_ACC_MAX_V = {1'b0, {(c_ACC_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_ACC_MIN_V = {1'b1, {(c_ACC_W-1){1'b0}}};
    localparam logic signed [c_ACC_W-1:0] c_PIX_MAX_V = c_ACC_W'((1 << PIXEL_W) - 1);

    logic                       w_accept, w_emit, w_line_end;
    logic [c_COL_W-1:0]         r_col, w_col;
    logic [1:0]                 r_row, w_row;
    logic [PIXEL_W-1:0]         w_lb_top, w_lb_mid;
    logic [PIXEL_W-1:0]         r_win [c_TAPS];
    kernel_e                    r_mode;
    logic                       r_en, r_in_frame, r_sof_pend;
    coef_arr_t                  r_coef;
    logic [2:0]                 r_shift;
    logic                       r_s0_valid, r_s0_sof, r_s0_sol;
    logic                       r_s1_valid, r_s1_sof, r_s1_sol;
    logic signed [c_ACC_W-1:0]  r_acc, w_acc_sat;
    logic [PIXEL_W-1:0]         w_clamped;
    int                         w_gauss, w_gx, w_gy, w_sharp, w_emb, w_cust, w_result;

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_col      = (in_sof || in_sol) ? '0 : r_col;
        w_row      = in_sof ? 2'd0 : r_row;
        w_line_end = (w_col == c_COL_W'(LINE_W - 1));
        // Frames interrupted by reset stay silent until the next in_sof.
        w_emit     = (r_in_frame || in_sof) && (w_row == 2'd2) && (w_col >= c_COL_W'(2));
    end

    conv_line_buffer #(
        .PIXEL_W (PIXEL_W),
        .LINE_W  (LINE_W)
    ) u_line_buffer (
        .clk    (clk),
        .wr_en  (w_accept),
        .addr   (w_col),
        .wr_top (w_lb_mid),
        .wr_mid (in_pixel),
        .rd_top (w_lb_top),
        .rd_mid (w_lb_mid)
    );

    always_comb begin
        w_gauss = 0; w_gx = 0; w_gy = 0; w_sharp = 0; w_emb = 0; w_cust = 0;
        for (int i = 0; i < c_TAPS; i++) begin
            w_gauss += c_K_GAUSS[i]   * int'(r_win[i]);
            w_gx    += c_K_SOBEL_X[i] * int'(r_win[i]);
            w_gy    += c_K_SOBEL_Y[i] * int'(r_win[i]);
            w_sharp += c_K_SHARPEN[i] * int'(r_win[i]);
            w_emb   += c_K_EMBOSS[i]  * int'(r_win[i]);
            w_cust  += int'(signed'(r_coef[i])) * int'(r_win[i]);
        end
    end

    always_comb begin
        w_result = int'(r_win[4]);
        if (r_en) begin
            case (r_mode)
                K_GAUSS:   w_result = (w_gauss + 8) >>> 4;
                K_SOBEL:   w_result = (iabs(w_gx) + iabs(w_gy)) >>> 2;
                K_SHARPEN: w_result = w_sharp;
                K_EMBOSS:  w_result = w_emb + c_EMBOSS_OFS;
                K_CUSTOM:  w_result = w_cust >>> r_shift;
                default:   w_result = int'(r_win[4]);
            endcase
        end
        // Saturating into the accumulator keeps the final clamp exact.
        if (w_result > int'(c_ACC_MAX_V))      w_acc_sat = c_ACC_MAX_V;
        else if (w_result < int'(c_ACC_MIN_V)) w_acc_sat = c_ACC_MIN_V;
        else                                   w_acc_sat = w_result[c_ACC_W-1:0];
    end

    always_comb begin
        if (r_acc[c_ACC_W-1])          w_clamped = '0;
        else if (r_acc > c_PIX_MAX_V)  w_clamped = '1;
        else                           w_clamped = r_acc[PIXEL_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= 2'd0;
            for (int i = 0; i < c_TAPS; i++) r_win[i] <= '0;
            r_mode     <= K_GAUSS;
            r_en       <= 1'b1;
            r_coef     <= '0;
            r_shift    <= 3'd0;
            r_in_frame <= 1'b0;
            r_sof_pend <= 1'b0;
            r_s0_valid <= 1'b0;
            r_s0_sof   <= 1'b0;
            r_s0_sol   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_sol   <= 1'b0;
            r_acc      <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_sof    <= 1'b0;
            out_sol    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col <= w_line_end ? '0 : w_col + 1'b1;
                r_row <= (w_line_end && w_row != 2'd2) ? w_row + 2'd1 : w_row;
                for (int r = 0; r < 3; r++) begin
                    r_win[3*r]   <= r_win[3*r+1];
                    r_win[3*r+1] <= r_win[3*r+2];
                end
                r_win[2] <= w_lb_top;
                r_win[5] <= w_lb_mid;
                r_win[8] <= in_pixel;
                if (in_sof) begin
                    r_in_frame <= 1'b1;
                    r_mode     <= kernel_e'(kernel_select);
                    r_en       <= enable;
                    r_coef     <= coef;
                    r_shift    <= coef_shift;
                    r_sof_pend <= 1'b1;
                end else if (w_emit) begin
                    r_sof_pend <= 1'b0;
                end
            end
            if (in_ready) begin
                r_s0_valid <= w_accept && w_emit;
                r_s0_sof   <= r_sof_pend;
                r_s0_sol   <= (w_col == c_COL_W'(2));
                r_s1_valid <= r_s0_valid;
                r_s1_sof   <= r_s0_sof;
                r_s1_sol   <= r_s0_sol;
                if (r_s0_valid) r_acc <= w_acc_sat;
                out_valid  <= r_s1_valid;
                out_sof    <= r_s1_valid && r_s1_sof;
                out_sol    <= r_s1_valid && r_s1_sol;
                if (r_s1_valid) out_pixel <= w_clamped;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_filter.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_stream_filter
// Brief  : Scoreboard bench for conv_stream_filter (PIXEL_W=4, LINE_W=8).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_conv_stream_filter;
    import conv_pkg::*;

    localparam int PW = 4;
    localparam int LW = 8;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          rst_n, enable, in_valid, in_ready, in_sof, in_sol;
    logic          out_valid, out_ready, out_sof, out_sol;
    logic [2:0]    kernel_select, coef_shift;
    coef_arr_t     coef;
    logic [PW-1:0] in_pixel, out_pixel;

    typedef struct {int pix; bit sof; bit sol;} exp_t;
    exp_t exp_q[$];

    int n_vec, n_miss, cyc, acc_cyc, n_out;
    bit lat_arm, bp_rand, force_stall;
    int img [H][LW];
    int coef_v [9];

    conv_stream_filter #(.PIXEL_W(PW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .kernel_select(kernel_select),
        .coef(coef), .coef_shift(coef_shift), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_sof(in_sof), .in_sol(in_sol), .out_valid(out_valid),
        .out_ready(out_ready), .out_pixel(out_pixel), .out_sof(out_sof), .out_sol(out_sol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : !force_stall;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: direct 3x3 arithmetic around centre (r,c) of the current image.
    function automatic int model_pix(int r, int c, int ks, bit en, int sh);
        int a [9];
        int gx, gy, s, res;
        for (int i = 0; i < 9; i++) a[i] = img[r-1+i/3][c-1+i%3];
        res = a[4];
        if (en) begin
            case (ks)
                0: res = (a[0] + 2*a[1] + a[2] + 2*a[3] + 4*a[4] + 2*a[5] + a[6] + 2*a[7] + a[8] + 8) / 16;
                1: begin
                    gx  = (a[2] + 2*a[5] + a[8]) - (a[0] + 2*a[3] + a[6]);
                    gy  = (a[6] + 2*a[7] + a[8]) - (a[0] + 2*a[1] + a[2]);
                    res = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 4;
                end
                2: res = 5*a[4] - a[1] - a[3] - a[5] - a[7];
                3: res = -2*a[0] - a[1] - a[3] + a[4] + a[5] + a[7] + 2*a[8] + (1 << (PW-1));
                4: begin
                    s = 0;
                    for (int i = 0; i < 9; i++) s += coef_v[i] * a[i];
                    res = s >>> sh;
                end
                default: res = a[4];
            endcase
        end
        if (res < 0) res = 0;
        if (res > (1 << PW) - 1) res = (1 << PW) - 1;
        return res;
    endfunction

    task automatic set_expect(input int ks, input bit en, input int sh, input int nrows);
        exp_t e;
        for (int r = 1; r + 1 < nrows; r++)
            for (int c = 1; c <= LW - 2; c++) begin
                e.pix = model_pix(r, c, ks, en, sh);
                e.sof = (r == 1 && c == 1);
                e.sol = (c == 1);
                exp_q.push_back(e);
            end
    endtask

    task automatic drive_px(input int pix, input bit sof, input bit sol, input int r, input int c);
        int t = 0;
        in_pixel = PW'(pix); in_sof = sof; in_sol = sol; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                $display("FAIL in_ready_timeout: got 0, expected 1");
                $fatal(1);
            end
        end
        if (r == 2 && c == 2) acc_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_sol = 1'b0;
    endtask

    // scram: 0 hold mode inputs, 1 switch kernel_select to Sobel, 2 randomise all.
    task automatic drive_rows(input int r0, input int r1, input bit with_sof, input int ks,
                              input bit en, input int sh, input int scram, input bit gaps);
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < LW; c++) begin
                bit sof = with_sof && r == 0 && c == 0;
                if (sof) begin
                    kernel_select = 3'(ks); enable = en; coef_shift = 3'(sh);
                    for (int i = 0; i < 9; i++) coef[i] = coef_t'(coef_v[i]);
                end else if (scram == 1) begin
                    kernel_select = 3'd1;
                end else if (scram == 2) begin
                    kernel_select = 3'($urandom_range(0, 7));
                    enable        = 1'($urandom);
                    coef_shift    = 3'($urandom);
                    for (int i = 0; i < 9; i++) coef[i] = coef_t'($urandom);
                end
                drive_px(img[r][c], sof, c == 0, r, c);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 600) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_outputs"}, n_out, 36);
    endtask

    task automatic run_frame(input string tag, input int ks, input bit en, input int sh,
                             input int scram, input bit gaps);
        n_out = 0;
        set_expect(ks, en, sh, H);
        drive_rows(0, H - 1, 1'b1, ks, en, sh, scram, gaps);
        drain(tag);
    endtask

    task automatic stall_proc();
        int t = 0;
        int held;
        while (n_out < 10 && t < 2000) begin @(negedge clk); t++; end
        force_stall = 1'b1;
        @(posedge clk); #2;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        chk("stall_out_valid", out_valid, 1);
        held = out_pixel;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_pixel_hold", out_pixel, held);
        end
        force_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (lat_arm && out_sof) begin
                lat_arm = 1'b0;
                chk("first_output_latency", cyc - acc_cyc, 2);
            end
            if (exp_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_output: got pixel %0d, expected no output", out_pixel);
            end else begin
                e = exp_q.pop_front();
                chk("out_pixel", out_pixel, e.pix);
                chk("out_sof", out_sof, e.sof);
                chk("out_sol", out_sol, e.sol);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sol = 1'b0; in_pixel = '0;
        enable = 1'b1; kernel_select = 3'd0; coef = '0; coef_shift = 3'd0;
        bp_rand = 1'b0; force_stall = 1'b0;
        for (int i = 0; i < 9; i++) coef_v[i] = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_sol", out_sol, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (img[r, c]) img[r][c] = 9;
        lat_arm = 1'b1;
        run_frame("gauss_const9", 0, 1'b1, 0, 0, 1'b0);
        chk("gauss_sof_seen", lat_arm, 0);

        foreach (img[r, c]) img[r][c] = (c < 4) ? 0 : 15;
        run_frame("sobel_step", 1, 1'b1, 0, 0, 1'b1);

        foreach (img[r, c]) img[r][c] = 0;
        img[4][4] = 15;
        run_frame("sharpen_impulse", 2, 1'b1, 0, 0, 1'b0);

        foreach (img[r, c]) img[r][c] = 5;
        run_frame("emboss_flat5", 3, 1'b1, 0, 1, 1'b0);

        foreach (img[r, c]) img[r][c] = $urandom_range(0, 15);
        n_out = 0;
        set_expect(0, 1'b1, 0, H);
        fork
            drive_rows(0, H - 1, 1'b1, 0, 1'b1, 0, 0, 1'b0);
            stall_proc();
        join
        drain("stall_frame");

        bp_rand = 1'b1;
        for (int f = 0; f < 5; f++) begin
            int ks, sh;
            bit en;
            foreach (img[r, c]) img[r][c] = $urandom_range(0, 15);
            for (int i = 0; i < 9; i++) coef_v[i] = int'($urandom_range(0, 15)) - 8;
            ks = (f == 0) ? 4 : $urandom_range(0, 7);
            en = ($urandom_range(0, 4) != 0);
            sh = $urandom_range(0, 7);
            run_frame("random_frame", ks, en, sh, 2, 1'b1);
        end
        bp_rand = 1'b0;

        // Reset after row 4, then finish the old frame without in_sof.
        foreach (img[r, c]) img[r][c] = $urandom_range(0, 15);
        n_out = 0;
        set_expect(0, 1'b1, 0, 5);
        drive_rows(0, 4, 1'b1, 0, 1'b1, 0, 0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_pixel", out_pixel, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_out = 0;
        drive_rows(5, 7, 1'b0, 0, 1'b1, 0, 0, 1'b0);
        repeat (6) @(negedge clk);
        chk("postreset_silent", n_out, 0);

        foreach (img[r, c]) img[r][c] = $urandom_range(0, 15);
        lat_arm = 1'b1;
        run_frame("postreset_frame", 0, 1'b1, 0, 0, 1'b0);
        chk("postreset_sof_seen", lat_arm, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
